// File: rtl/clk_div_sched.sv
// clk_div_sched: multi-channel divided strobes/clocks with period-boundary reconfiguration
module clk_div_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  input  logic              cfg_en_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic              busy_o
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_nx;
  logic [CH_W-1:0] req_ch;
  logic [CNT_W-1:0] req_div;
  logic req_en;
  logic [NUM_CH-1:0] en, dclk, hit, go;
  logic [CNT_W-1:0] div [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic oor, apply;
  assign oor = int'(req_ch) >= NUM_CH;
  assign apply = (state == PEND) & (oor | |go);
  assign cfg_ready_o = state == IDLE;
  assign busy_o = ~cfg_ready_o;
  assign div_clk_o = dclk;
  // Terminal-count strobes and the per-channel apply condition for the pending request
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tick_o[c] = en[c] & (cnt[c] == div[c] - CNT_W'(1));
      hit[c] = (state == PEND) & (req_ch == CH_W'(c));
      go[c] = hit[c] & (~en[c] | (tick_o[c] & (req_en | dclk[c])));
    end
  end
  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  end
  // Accept in IDLE, return once the pending request has been applied or dropped
  always_comb begin
    state_nx = (state == IDLE) ? (cfg_valid_i ? PEND : IDLE) : (apply ? IDLE : PEND);
  end
  // Latch request fields on acceptance; a zero divisor is stored as one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_ch <= '0;
      req_div <= CNT_W'(1);
      req_en <= 1'b0;
    end else if (cfg_valid_i & cfg_ready_o) begin
      req_ch <= cfg_ch_i;
      req_div <= (cfg_div_i == '0) ? CNT_W'(1) : cfg_div_i;
      req_en <= cfg_en_i;
    end
  end
  // Channel counters and divided clocks, with the pending change applied at its boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en[c] <= 1'b0;
        dclk[c] <= 1'b0;
        div[c] <= CNT_W'(1);
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (go[c] & ~en[c]) begin
          div[c] <= req_div;
          if (req_en) begin
            en[c] <= 1'b1;
            cnt[c] <= '0;
            dclk[c] <= 1'b0;
          end
        end else if (go[c] & ~req_en) begin
          en[c] <= 1'b0;
          cnt[c] <= '0;
          dclk[c] <= 1'b0;
        end else if (en[c]) begin
          cnt[c] <= tick_o[c] ? '0 : cnt[c] + CNT_W'(1);
          dclk[c] <= dclk[c] ^ tick_o[c];
          if (go[c]) div[c] <= req_div;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed checks of divider channels and deferred reconfiguration
module tb_clk_div_sched;
  localparam int NUM_CH = 3;
  localparam int CNT_W = 4;
  logic clk_i = 1'b0, rst_i = 1'b0, cfg_valid_i = 1'b0, cfg_en_i = 1'b0;
  logic [1:0] cfg_ch_i = '0;
  logic [CNT_W-1:0] cfg_div_i = '0;
  logic cfg_ready_o, busy_o;
  logic [NUM_CH-1:0] tick_o, div_clk_o;
  int checks = 0, failures = 0, n = 0;
  int db [NUM_CH] = '{1, 1, 1};
  int bb [NUM_CH] = '{0, 0, 0};
  int ph [NUM_CH] = '{0, 0, 0};
  logic [NUM_CH-1:0] on = '0, msk = '1;

  clk_div_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i), .cfg_en_i(cfg_en_i),
    .tick_o(tick_o), .div_clk_o(div_clk_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
    n++;
  endtask

  task automatic start(input int c, input int d, input int p);
    on[c] = 1'b1;
    db[c] = d;
    bb[c] = n;
    ph[c] = p;
  endtask

  task automatic chk_model(input string tag);
    logic [NUM_CH-1:0] et, ed;
    for (int c = 0; c < NUM_CH; c++) begin
      et[c] = on[c] && ((n - bb[c]) % db[c] == db[c] - 1);
      ed[c] = on[c] && ((((n - bb[c]) / db[c]) % 2) != ph[c]);
    end
    chk({tag, " tick"}, 32'(tick_o & msk), 32'(et & msk));
    chk({tag, " dclk"}, 32'(div_clk_o & msk), 32'(ed & msk));
  endtask

  task automatic cfg(input int ch, input int d, input logic e);
    cfg_valid_i = 1'b1;
    cfg_ch_i = 2'(ch);
    cfg_div_i = CNT_W'(d);
    cfg_en_i = e;
    nxt();
    cfg_valid_i = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0] acc;
    int b;
    #2 rst_i = 1'b1;
    #1 chk("rst tick", 32'(tick_o), 0);
    chk("rst dclk", 32'(div_clk_o), 0);
    chk("rst ready", 32'(cfg_ready_o), 1);
    chk("rst busy", 32'(busy_o), 0);
    nxt();
    rst_i = 1'b0;
    acc = '0;
    repeat (100) begin
      nxt();
      acc |= tick_o | div_clk_o;
    end
    chk("idle outputs", 32'(acc), 0);
    chk("idle ready", 32'(cfg_ready_o), 1);
    // ch0 enable D=3
    cfg(0, 3, 1);
    chk("en0 busy", 32'(busy_o), 1);
    chk("en0 ready", 32'(cfg_ready_o), 0);
    chk("en0 tick", 32'(tick_o), 0);
    nxt();
    chk("en0 applied", 32'(busy_o), 0);
    start(0, 3, 0);
    repeat (60) begin
      chk_model("ch0 d3");
      nxt();
    end
    // ch1 D=4 then D=2 requested mid-period
    cfg(1, 4, 1);
    chk("en1 busy", 32'(busy_o), 1);
    nxt();
    start(1, 4, 0);
    chk_model("ch1 d4");
    nxt();
    chk_model("ch1 d4");
    cfg(1, 2, 1);
    chk("chg1 busy a", 32'(busy_o), 1);
    chk_model("ch1 old");
    nxt();
    chk("chg1 busy b", 32'(busy_o), 1);
    chk_model("ch1 old");
    nxt();
    chk("chg1 done", 32'(busy_o), 0);
    start(1, 2, 1);
    repeat (20) begin
      chk_model("ch1 d2");
      nxt();
    end
    // ch2 D=5, disable requested during the low phase
    cfg(2, 5, 1);
    nxt();
    b = n;
    msk = 3'b011;
    chk("ch2 tick j0", 32'(tick_o[2]), 0);
    chk("ch2 dclk j0", 32'(div_clk_o[2]), 0);
    nxt();
    chk("ch2 dclk j1", 32'(div_clk_o[2]), 0);
    cfg(2, 5, 0);
    for (int j = 2; j <= 40; j++) begin
      chk("dis busy", 32'(busy_o), 32'(j <= 9));
      chk("dis tick2", 32'(tick_o[2]), 32'(j == 4 || j == 9));
      chk("dis dclk2", 32'(div_clk_o[2]), 32'(j >= 5 && j <= 9));
      chk_model("dis others");
      nxt();
    end
    chk("dis elapsed", 32'(n - b), 41);
    msk = '1;
    // ch2 D=0, then D=1, then D=15 (max)
    cfg(2, 0, 1);
    chk("d0 busy", 32'(busy_o), 1);
    nxt();
    start(2, 1, 0);
    repeat (9) begin
      chk_model("ch2 d0");
      nxt();
    end
    chk_model("ch2 d0");
    cfg(2, 1, 1);
    chk("d1 busy", 32'(busy_o), 1);
    chk_model("ch2 d1");
    nxt();
    chk("d1 done", 32'(busy_o), 0);
    repeat (9) begin
      chk_model("ch2 d1");
      nxt();
    end
    chk_model("ch2 d1");
    cfg(2, 15, 1);
    chk("d15 busy", 32'(busy_o), 1);
    chk_model("ch2 pre15");
    nxt();
    chk("d15 done", 32'(busy_o), 0);
    start(2, 15, 0);
    repeat (60) begin
      chk_model("ch2 d15");
      nxt();
    end
    // out-of-range channel, valid held for a second request
    cfg_valid_i = 1'b1;
    cfg_ch_i = 2'd3;
    cfg_div_i = 4'd7;
    cfg_en_i = 1'b1;
    nxt();
    chk("oor busy", 32'(busy_o), 1);
    cfg_ch_i = 2'd0;
    cfg_div_i = 4'd3;
    chk_model("oor a");
    nxt();
    chk("oor done", 32'(busy_o), 0);
    chk_model("oor b");
    nxt();
    chk("b2b busy", 32'(busy_o), 1);
    cfg_valid_i = 1'b0;
    chk_model("b2b a");
    for (int k = 0; k < 10 && busy_o; k++) begin
      nxt();
      chk_model("b2b wait");
    end
    chk("b2b done", 32'(busy_o), 0);
    repeat (10) begin
      nxt();
      chk_model("after b2b");
    end
    // reset while a disable is pending
    cfg(2, 0, 0);
    chk("pend busy", 32'(busy_o), 1);
    nxt();
    #2 rst_i = 1'b1;
    #1 chk("mid rst tick", 32'(tick_o), 0);
    chk("mid rst dclk", 32'(div_clk_o), 0);
    chk("mid rst ready", 32'(cfg_ready_o), 1);
    chk("mid rst busy", 32'(busy_o), 0);
    nxt();
    rst_i = 1'b0;
    acc = '0;
    repeat (20) begin
      nxt();
      acc |= tick_o | div_clk_o;
    end
    chk("post rst outputs", 32'(acc), 0);
    chk("post rst busy", 32'(busy_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
